// File: rtl/cpu_loader.sv
// Host-side loader that fills IMEM/DMEM, runs the core and streams DMEM back.
// Define LOADER_CHECKSUM_EN to require an XOR trailer word after every write block.
module cpu_loader #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_INC = 4,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              cpu_enable,
    output logic              err,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2
);

    localparam logic [1:0]  OpImem   = 2'b00;
    localparam logic [1:0]  OpRun    = 2'b10;
    localparam logic [1:0]  OpRead   = 2'b11;
    localparam logic [31:0] AddrInc  = 32'(ADDR_INC);
    localparam logic [7:0]  WaitLast = 8'(RD_LAT - 1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle, StGetAddr, StWrite, StRdReq, StRdWait, StRdOut, StRun, StChk
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StGetAddr, StWrite, StRdReq, StRdWait, StRdOut, StRun
    } state_e;
`endif

    state_e      state;
    logic [1:0]  op_q;
    logic [15:0] cnt_q;
    logic [31:0] addr_q;
    logic [7:0]  wait_q;
    logic        run_free_q;

    logic        accept;
    logic        take_hdr;
    logic [1:0]  hdr_op;
    logic [15:0] hdr_cnt;
    logic [31:0] addr_nxt;
    logic        last_word;

    // The IMEM port is write-only from the loader's side.
    assign ren_ext = 1'b0;

    always_comb begin
        accept    = in_valid && in_ready;
        // A free run is interrupted by the next header, handled as if in idle.
        take_hdr  = accept && ((state == StIdle) || ((state == StRun) && run_free_q));
        hdr_op    = in_data[31:30];
        hdr_cnt   = in_data[15:0];
        addr_nxt  = addr_q + AddrInc;
        last_word = (cnt_q == 16'd1);
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] xor_q;
    logic              err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= StIdle;
            op_q        <= 2'b00;
            cnt_q       <= 16'd0;
            addr_q      <= 32'd0;
            wait_q      <= 8'd0;
            run_free_q  <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            cpu_enable  <= 1'b0;
            addr_ext    <= 32'd0;
            wen_ext     <= 1'b0;
            wdata_ext   <= '0;
            addr_ext_2  <= 32'd0;
            wen_ext_2   <= 1'b0;
            ren_ext_2   <= 1'b0;
            wdata_ext_2 <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            wen_ext   <= 1'b0;
            wen_ext_2 <= 1'b0;
            ren_ext_2 <= 1'b0;

            if (take_hdr) begin
                op_q  <= hdr_op;
                cnt_q <= hdr_cnt;
                busy  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                xor_q <= '0;
`endif
                if (hdr_op == OpRun) begin
                    state      <= StRun;
                    cpu_enable <= 1'b1;
                    run_free_q <= (hdr_cnt == 16'd0);
                    in_ready   <= (hdr_cnt == 16'd0);
                end else begin
                    state      <= StGetAddr;
                    cpu_enable <= 1'b0;
                    run_free_q <= 1'b0;
                    in_ready   <= 1'b1;
                end
            end else begin
                unique case (state)
                    StIdle: begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end

                    StGetAddr: begin
                        if (accept) begin
                            addr_q <= in_data[31:0];
                            if (cnt_q == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                if (op_q != OpRead) begin
                                    state <= StChk;
                                end else begin
                                    state <= StIdle;
                                    busy  <= 1'b0;
                                end
`else
                                state <= StIdle;
                                busy  <= 1'b0;
`endif
                            end else if (op_q == OpRead) begin
                                state      <= StRdReq;
                                in_ready   <= 1'b0;
                                ren_ext_2  <= 1'b1;
                                addr_ext_2 <= in_data[31:0];
                            end else begin
                                state <= StWrite;
                            end
                        end
                    end

                    StWrite: begin
                        if (accept) begin
                            if (op_q == OpImem) begin
                                wen_ext   <= 1'b1;
                                addr_ext  <= addr_q;
                                wdata_ext <= in_data;
                            end else begin
                                wen_ext_2   <= 1'b1;
                                addr_ext_2  <= addr_q;
                                wdata_ext_2 <= in_data;
                            end
                            addr_q <= addr_nxt;
                            cnt_q  <= cnt_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                            xor_q  <= xor_q ^ in_data;
                            if (last_word) begin
                                state <= StChk;
                            end
`else
                            if (last_word) begin
                                state <= StIdle;
                                busy  <= 1'b0;
                            end
`endif
                        end
                    end

                    StRdReq: begin
                        state  <= StRdWait;
                        wait_q <= 8'd0;
                    end

                    StRdWait: begin
                        if (wait_q == WaitLast) begin
                            out_data  <= rdata_ext_2;
                            out_valid <= 1'b1;
                            state     <= StRdOut;
                        end else begin
                            wait_q <= wait_q + 8'd1;
                        end
                    end

                    StRdOut: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            addr_q    <= addr_nxt;
                            cnt_q     <= cnt_q - 16'd1;
                            if (last_word) begin
                                state    <= StIdle;
                                busy     <= 1'b0;
                                in_ready <= 1'b1;
                            end else begin
                                state      <= StRdReq;
                                ren_ext_2  <= 1'b1;
                                addr_ext_2 <= addr_nxt;
                            end
                        end
                    end

                    StRun: begin
                        if (!run_free_q) begin
                            if (last_word) begin
                                state      <= StIdle;
                                cpu_enable <= 1'b0;
                                busy       <= 1'b0;
                                in_ready   <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q - 16'd1;
                            end
                        end
                    end

`ifdef LOADER_CHECKSUM_EN
                    StChk: begin
                        if (accept) begin
                            if (in_data != xor_q) begin
                                err_q <= 1'b1;
                            end
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
`endif

                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_loader.sv
// Directed bench for cpu_loader: memory write blocks, bounded/free run, DMEM readback,
// mid-block reset and (with LOADER_CHECKSUM_EN) the trailer checksum.
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        srst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        cpu_enable;
    logic        err;
    logic [31:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [31:0] wdata_ext_2;
    logic [31:0] rdata_ext_2 = 32'd0;

    always #5 clk = ~clk;

    cpu_loader dut (
        .clk         (clk),
        .srst        (srst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .cpu_enable  (cpu_enable),
        .err         (err),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2)
    );

    // Memory-side observer and DMEM model with one cycle read latency.
    logic [31:0] dmem [0:63];
    logic [31:0] wa[$], wd[$], w2a[$], w2d[$];
    int          wt[$], w2t[$];
    int          cyc = 0;
    int          ren2_cnt = 0;
    int          ovl_cnt = 0;
    int          ren1_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wen_ext) begin
            wa.push_back(addr_ext);
            wd.push_back(wdata_ext);
            wt.push_back(cyc);
        end
        if (wen_ext_2) begin
            w2a.push_back(addr_ext_2);
            w2d.push_back(wdata_ext_2);
            w2t.push_back(cyc);
            dmem[addr_ext_2[7:2]] <= wdata_ext_2;
        end
        if (ren_ext_2) begin
            ren2_cnt    <= ren2_cnt + 1;
            rdata_ext_2 <= dmem[addr_ext_2[7:2]];
        end
        if (ren_ext) ren1_cnt <= ren1_cnt + 1;
        if (cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2))
            ovl_cnt <= ovl_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic recv(input string tag, input logic [31:0] exp);
        wait_out(tag);
        chk(tag, out_data, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    localparam logic [31:0] DA = 32'hA5A5_0001, DB = 32'h1234_5678, DC = 32'h0F0F_F0F0;
    localparam logic [31:0] D0 = 32'hCAFE_0001, D1 = 32'hCAFE_0002;

    int          b, b2, r0, en, bad;
    logic [31:0] hold;

    initial begin
        srst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        step(); step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_en", {31'd0, cpu_enable}, 32'd0);
        chk("rst_wen", {31'd0, wen_ext}, 32'd0);
        chk("rst_oval", {31'd0, out_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        srst = 1'b0;
        step();
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // IMEM block at full rate
        b = wa.size(); b2 = w2a.size();
        send(32'h0000_0003); send(32'h0000_0010); send(DA); send(DB); send(DC);
`ifdef LOADER_CHECKSUM_EN
        send(DA ^ DB ^ DC);
`endif
        step(); step();
        chk("t1_count", wa.size() - b, 32'd3);
        for (int k = 0; k < 3; k++) chk("t1_addr", wa[b+k], 32'h10 + 32'(4 * k));
        chk("t1_data0", wd[b], DA);
        chk("t1_data1", wd[b+1], DB);
        chk("t1_data2", wd[b+2], DC);
        chk("t1_gap01", wt[b+1] - wt[b], 32'd1);
        chk("t1_gap12", wt[b+2] - wt[b+1], 32'd1);
        chk("t1_dmem", w2a.size() - b2, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);

        // DMEM block with gapped valid
        b = wa.size(); b2 = w2a.size();
        send(32'h4000_0002); send(32'h0000_0000); send(D0);
        step();
        send(D1);
`ifdef LOADER_CHECKSUM_EN
        send(D0 ^ D1);
`endif
        step(); step();
        chk("t2_count", w2a.size() - b2, 32'd2);
        chk("t2_addr0", w2a[b2], 32'h0);
        chk("t2_addr1", w2a[b2+1], 32'h4);
        chk("t2_data0", w2d[b2], D0);
        chk("t2_data1", w2d[b2+1], D1);
        chk("t2_gap", w2t[b2+1] - w2t[b2], 32'd2);
        chk("t2_imem", wa.size() - b, 32'd0);

        // Bounded run of 5 cycles
        send(32'h8000_0005);
        en = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (cpu_enable) begin
                en++;
                if (in_ready) bad++;
            end
            step();
        end
        chk("t3_en_cycles", en, 32'd5);
        chk("t3_ready_low", bad, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd0);

        // Free run interrupted by a DMEM read header
        send(32'h8000_0000);
        chk("t3_free_en", {31'd0, cpu_enable}, 32'd1);
        chk("t3_free_rdy", {31'd0, in_ready}, 32'd1);
        repeat (20) step();
        chk("t3_free_hold", {31'd0, cpu_enable}, 32'd1);
        send(32'hC000_0002);
        chk("t3_drop", {31'd0, cpu_enable}, 32'd0);
        chk("t3_busy2", {31'd0, busy}, 32'd1);
        send(32'h0000_0000);
        recv("t3_rd0", D0);
        recv("t3_rd1", D1);
        step();
        chk("t3_idle", {31'd0, busy}, 32'd0);

        // Stalled readback of 1,2,3
        send(32'h4000_0003); send(32'h0000_0000);
        send(32'd1); send(32'd2); send(32'd3);
`ifdef LOADER_CHECKSUM_EN
        send(32'd0);
`endif
        step();
        r0 = ren2_cnt;
        send(32'hC000_0003); send(32'h0000_0000);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            wait_out("t4_valid");
            chk("t4_data", out_data, 32'(k + 1));
            hold = out_data;
            repeat (4) begin
                step();
                if (!out_valid || out_data !== hold) bad++;
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk("t4_stable", bad, 32'd0);
        step();
        chk("t4_ren_pulses", ren2_cnt - r0, 32'd3);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a 4-word IMEM block
        b = wa.size();
        send(32'h0000_0004); send(32'h0000_0040); send(32'h11); send(32'h22);
        srst = 1'b1;
        step();
        chk("t5_wen", {31'd0, wen_ext}, 32'd0);
        chk("t5_addr", addr_ext, 32'd0);
        chk("t5_wdata", wdata_ext, 32'd0);
        chk("t5_addr2", addr_ext_2, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_en", {31'd0, cpu_enable}, 32'd0);
        chk("t5_oval", {31'd0, out_valid}, 32'd0);
        srst = 1'b0;
        step();
        chk("t5_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_partial", wa.size() - b, 32'd2);
        b = wa.size();
        send(32'h0000_0001); send(32'h0000_0080); send(32'h99);
`ifdef LOADER_CHECKSUM_EN
        send(32'h99);
`endif
        step(); step();
        chk("t5_count", wa.size() - b, 32'd1);
        chk("t5_naddr", wa[b], 32'h80);
        chk("t5_ndata", wd[b], 32'h99);
        chk("t5_busy2", {31'd0, busy}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
        send(32'h0000_0002); send(32'h0000_0100); send(32'd5); send(32'd3); send(32'd6);
        step();
        chk("t6_good", {31'd0, err}, 32'd0);
        send(32'h0000_0002); send(32'h0000_0100); send(32'd5); send(32'd3); send(32'd7);
        step();
        chk("t6_bad", {31'd0, err}, 32'd1);
        repeat (5) step();
        chk("t6_sticky", {31'd0, err}, 32'd1);
        srst = 1'b1;
        step();
        srst = 1'b0;
        step();
        chk("t6_clear", {31'd0, err}, 32'd0);
`else
        chk("t6_err_tied", {31'd0, err}, 32'd0);
`endif

        chk("overlap", ovl_cnt, 32'd0);
        chk("imem_ren", ren1_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_loader.md
Name: cpu_loader

Overview:
- Host-side front end that sits directly upstream of the cpu top and drives its external memory ports (addr_ext/wen_ext/ren_ext/wdata_ext and the _2 data-memory set) and its enable input.
- Receives a 32-bit command/data word stream over a valid/ready handshake. Writes program and data blocks into IMEM/DMEM, releases the core for a bounded or free run, and streams DMEM contents back out.
- Guarantees the core never runs while memories are being loaded or read.

Parameters:
- DATA_W, 32, width of stream words and memory words.
- ADDR_INC, 4, increment applied to the external address per word (byte addressing).
- RD_LAT, 1, cycles from ren_ext_2 assertion to valid rdata_ext_2.

Ports:
- clk  in  1  main clock
- srst  in  1  synchronous active-high reset
- in_valid  in  1  command stream word valid
- in_ready  out  1  loader accepts in_data this cycle
- in_data  in  DATA_W  command stream word
- out_valid  out  1  readback word valid
- out_ready  in  1  sink accepts out_data
- out_data  out  DATA_W  readback word
- busy  out  1  high in any state other than IDLE
- cpu_enable  out  1  drives cpu enable
- err  out  1  sticky checksum error (feature only; else 0)
- addr_ext, wen_ext, ren_ext, wdata_ext  out  32/1/1/32  IMEM external port
- addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2  out  32/1/1/32  DMEM external port
- rdata_ext_2  in  32  DMEM external read data

Behaviour:
- Handshake: a word transfers on a cycle with in_valid && in_ready, and likewise out_valid && out_ready. out_data and out_valid hold stable until accepted.
- Header word: op = [31:30], count N = [15:0], bits [29:16] ignored.
- op encoding: 00 = write IMEM block, 01 = write DMEM block, 10 = run, 11 = read DMEM block.
- States: IDLE, GET_ADDR, WRITE, RD_REQ, RD_WAIT, RD_OUT, RUN, CHK (feature only).
- IDLE: in_ready=1. On header: op 00/01/11 -> GET_ADDR; op 10 -> RUN.
- GET_ADDR: in_ready=1. The accepted word is the base byte address. Next state is WRITE for op 00/01 or RD_REQ for op 11. If N=0, go to IDLE (or CHK for a write with the feature on) with no memory access.
- WRITE: in_ready=1, one word per cycle. Each accepted word is registered. The following cycle drives wen=1 on the selected port with addr = base + k*ADDR_INC and wdata = the word; ren stays 0.
  - Write latency is 1 cycle.
  - After word N is accepted, go to IDLE (or CHK).
  - The final wen pulse still issues on the cycle after leaving WRITE.
- RD_REQ: one cycle with ren_ext_2=1 and addr_ext_2 = current address.
- RD_WAIT: lasts RD_LAT cycles, then captures rdata_ext_2 into out_data.
- RD_OUT: out_valid=1 until accepted. Then advance the address and go to RD_REQ, or to IDLE after N words.
- RUN: cpu_enable=1.
  - N>0: exactly N cycles of enable, then IDLE; in_ready=0.
  - N=0: free run with in_ready=1. The next accepted header deasserts enable in the same cycle and is processed as if received in IDLE.
- cpu_enable is never high in the same cycle as any wen/ren. in_ready=0 in RD_*.
- Address arithmetic is 32-bit modulo 2^32 (wraps silently). Range checking against memory depth is the host's responsibility.
- The word counter is 16 bits, so N up to 65535 is supported.
- All outputs are registered.
- Reset (synchronous, any cycle, including mid-block or mid-run):
  - Next edge enters IDLE.
  - in_ready=1 one cycle after reset deassertion.
  - out_valid, cpu_enable, busy, err, all wen/ren, addresses and wdata go to 0.
  - A partial block is abandoned; words already written remain in memory.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- With it:
  - A write block of N words (N>=0) is followed by one trailer word, accepted in CHK.
  - The trailer is compared against the XOR of all N data words (XOR is 0 when N=0).
  - A mismatch sets err, which stays set until srst.
  - Written words are not rolled back.
  - CHK then returns to IDLE.
- Without it: no trailer word, no CHK state, err tied 0.

Test Plan:
- Header 0x0000_0003, addr 0x10, data A,B,C at full rate -> wen_ext pulses 3 consecutive cycles at 0x10/0x14/0x18 with A/B/C. wen_ext_2 stays 0, busy returns to 0.
- Same block to DMEM (0x4000_0002, addr 0x0) with in_valid gapped every other cycle -> exactly 2 wen_ext_2 pulses at 0x0/0x4. No pulse on idle cycles.
- Header 0x8000_0005 -> cpu_enable high exactly 5 cycles, in_ready 0 during RUN. Then 0x8000_0000 followed 20 cycles later by a DMEM-read header -> enable drops the cycle that header is accepted.
- Preload DMEM 0x0..0x8 with 1,2,3; header 0xC000_0003, addr 0x0, out_ready low 4 cycles per word -> out_data 1,2,3 in order, each held stable while stalled, one ren_ext_2 pulse per word.
- srst asserted after 2 of 4 words of an IMEM block -> all outputs 0 next cycle. A subsequent 1-word block executes normally at its own address.
- With LOADER_CHECKSUM_EN: block 5,3 plus trailer 6 -> err stays 0; block 5,3 plus trailer 7 -> err=1 until srst.
